risc_v_run_controller: RTL and testbench

RISC_V_RUN_CONTROLLER -- requirements
Module: riscv_run_controller

---
 rtl/risc_v_run_controller.sv | 207 ++++++++++++++++++++
 tb/tb_risc_v_run_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/risc_v_run_controller.sv
// Program-load / clear / run / register-check sequencer for a RISC-V core under test.
// Optional data dump stream is compiled in with `define RUN_CTRL_DUMP_EN.
module risc_v_run_controller #(
  parameter int PROG_WORDS  = 64,
  parameter int DATA_BASE   = 8192,
  parameter int ADDR_W      = 14,
  parameter int CLEAR_WORDS = 64,
  parameter int RUN_CYCLES  = 50,
  parameter int NUM_CHECKS  = 3,
  parameter int DUMP_WORDS  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     halt,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [31:0]              rom_data,
  output logic                     mem_sel,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata,
  output logic                     core_reset,
  output logic                     core_stall,
  output logic [4:0]               reg_rd_addr,
  input  logic [31:0]              reg_rd_data,
  input  logic [5*NUM_CHECKS-1:0]  chk_reg,
  input  logic [32*NUM_CHECKS-1:0] chk_val,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [7:0]               err_count,
  output logic [7:0]               fail_idx,
  output logic [15:0]              cycle_count
`ifdef RUN_CTRL_DUMP_EN
  ,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [31:0]              dump_data
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_RUN, S_CHECK, S_DUMP, S_DONE
  } state_t;

  localparam logic [31:0]       PROG_LAST  = 32'(PROG_WORDS - 1);
  localparam logic [31:0]       CLEAR_LAST = 32'(CLEAR_WORDS - 1);
  localparam logic [31:0]       RUN_LAST   = 32'(RUN_CYCLES - 1);
  localparam logic [31:0]       CHK_LAST   = 32'(NUM_CHECKS - 1);
  localparam logic [ADDR_W-1:0] BASE_A     = ADDR_W'(DATA_BASE);

  state_t      state, state_nxt;
  logic [31:0] idx;
  logic        step;
  logic [4:0]  chk_reg_cur;
  logic [31:0] chk_val_cur;
  logic        chk_miss;

`ifndef RUN_CTRL_DUMP_EN
  logic unused_dump;
  assign unused_dump = ^{mem_rdata, 32'(DUMP_WORDS)};
`endif

  // Select the check entry addressed by the shared per-state index.
  always_comb begin
    chk_reg_cur = '0;
    chk_val_cur = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (idx == 32'(i)) begin
        chk_reg_cur = chk_reg[i*5 +: 5];
        chk_val_cur = chk_val[i*32 +: 32];
      end
    end
  end

  assign chk_miss = (reg_rd_data != chk_val_cur);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    step      = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        step = 1'b1;
        if (idx == PROG_LAST) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        step = 1'b1;
        if (idx == CLEAR_LAST) state_nxt = S_RUN;
      end
      S_RUN: begin
        step = 1'b1;
        if (halt || idx == RUN_LAST) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        step = 1'b1;
`ifdef RUN_CTRL_DUMP_EN
        if (idx == CHK_LAST) state_nxt = S_DUMP;
`else
        if (idx == CHK_LAST) state_nxt = S_DONE;
`endif
      end
      S_DUMP: begin
`ifdef RUN_CTRL_DUMP_EN
        // dump_valid is always high here, so ready alone marks an accepted word
        step = dump_ready;
        if (dump_ready && idx == 32'(DUMP_WORDS - 1)) state_nxt = S_DONE;
`else
        state_nxt = S_DONE;
`endif
      end
      S_DONE:  if (start) state_nxt = S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx         <= '0;
      err_count   <= '0;
      fail_idx    <= 8'hFF;
      cycle_count <= '0;
    end else begin
      if (state_nxt != state) idx <= '0;
      else if (step)          idx <= idx + 32'd1;

      if ((state == S_IDLE || state == S_DONE) && start) begin
        err_count   <= '0;
        fail_idx    <= 8'hFF;
        cycle_count <= '0;
      end

      if (state == S_RUN && cycle_count != 16'hFFFF)
        cycle_count <= cycle_count + 16'd1;

      if (state == S_CHECK && chk_miss) begin
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        if (err_count == 8'd0)  fail_idx  <= idx[7:0];
      end
    end
  end

  always_comb begin
    rom_addr    = '0;
    mem_sel     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    core_reset  = 1'b0;
    core_stall  = 1'b0;
    reg_rd_addr = '0;
    busy        = 1'b1;
    done        = 1'b0;
    pass        = 1'b0;
`ifdef RUN_CTRL_DUMP_EN
    dump_valid  = 1'b0;
    dump_data   = '0;
`endif
    case (state)
      S_IDLE: begin
        busy       = 1'b0;
        core_reset = 1'b1;
      end
      S_LOAD: begin
        core_reset = 1'b1;
        mem_sel    = 1'b1;
        mem_we     = 1'b1;
        rom_addr   = idx[ADDR_W-1:0];
        mem_addr   = idx[ADDR_W-1:0];
        mem_wdata  = rom_data;
      end
      S_CLEAR: begin
        core_reset = 1'b1;
        mem_sel    = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = BASE_A + idx[ADDR_W-1:0];
      end
      S_CHECK: begin
        core_stall  = 1'b1;
        reg_rd_addr = chk_reg_cur;
      end
      S_DUMP: begin
        core_stall = 1'b1;
`ifdef RUN_CTRL_DUMP_EN
        mem_sel    = 1'b1;
        mem_addr   = BASE_A + idx[ADDR_W-1:0];
        dump_valid = 1'b1;
        dump_data  = mem_rdata;
`endif
      end
      S_DONE: begin
        core_stall = 1'b1;
        busy       = 1'b0;
        done       = 1'b1;
        pass       = (err_count == 8'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_risc_v_run_controller.sv
// Randomized bench for risc_v_run_controller: transaction-level model of load/clear/run/check.
module tb_risc_v_run_controller;
  localparam int PW = 64, DB = 8192, AW = 14, CW = 64, RC = 50, NC = 3, DW = 16;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, halt;
  logic [AW-1:0] rom_addr, mem_addr;
  logic [31:0] rom_data, mem_wdata, mem_rdata, reg_rd_data;
  logic mem_sel, mem_we, core_reset, core_stall, busy, done, pass;
  logic [4:0] reg_rd_addr;
  logic [5*NC-1:0] chk_reg;
  logic [32*NC-1:0] chk_val;
  logic [7:0] err_count, fail_idx;
  logic [15:0] cycle_count;
`ifdef RUN_CTRL_DUMP_EN
  logic dump_valid, dump_ready = 1'b0;
  logic [31:0] dump_data;
`endif

  logic [31:0] rom  [0:(1<<AW)-1];
  logic [31:0] mem  [0:(1<<AW)-1];
  logic [31:0] regs [0:31];
  int tests = 0, fails = 0;
  int halt_at = 0;
  int run_seen = 0;
  logic halt_noise = 1'b0;
  logic in_run;

  risc_v_run_controller dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .core_reset(core_reset), .core_stall(core_stall),
    .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .chk_reg(chk_reg), .chk_val(chk_val),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_idx(fail_idx), .cycle_count(cycle_count)
`ifdef RUN_CTRL_DUMP_EN
    , .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data)
`endif
  );

  always #5 clk = ~clk;

  assign rom_data    = rom[rom_addr];
  assign mem_rdata   = mem[mem_addr];
  assign reg_rd_data = regs[reg_rd_addr];
  assign in_run      = !core_reset && !core_stall;
  // Core stand-in: halts on the requested run cycle; noise outside RUN must be ignored.
  assign halt = in_run ? (halt_at != 0 && run_seen == halt_at - 1) : halt_noise;

  always @(posedge clk) begin
    if (start && !busy) run_seen <= 0;
    else if (in_run)    run_seen <= run_seen + 1;
    if (mem_sel && mem_we) mem[mem_addr] <= mem_wdata;
    else if (in_run)       mem[DB + (run_seen % DW)] <= 32'(run_seen) + 32'd8;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic setup(input logic [NC-1:0] badmask);
    int r;
    for (int k = 0; k < PW; k++) rom[k] = $urandom;
    for (int k = 0; k < 32; k++) regs[k] = $urandom;
    for (int i = 0; i < NC; i++) begin
      r = $urandom_range(0, 31);
      chk_reg[i*5 +: 5]   = 5'(r);
      chk_val[i*32 +: 32] = regs[r] ^ (badmask[i] ? (32'd1 << $urandom_range(0, 31)) : 32'd0);
    end
  endtask

  task automatic run_check(input int h, input bit mid_start);
    int exp_cyc, exp_err, exp_fail, nw, nrun, nchk, ndump, dcyc, cyc, bad;
    bit finished, prev_halt;
    exp_cyc = (h >= 1 && h <= RC) ? h : RC;
    exp_err = 0; exp_fail = 255;
    for (int i = 0; i < NC; i++)
      if (chk_val[i*32 +: 32] != regs[chk_reg[i*5 +: 5]]) begin
        if (exp_err == 0) exp_fail = i;
        exp_err++;
      end
    nw = 0; nrun = 0; nchk = 0; ndump = 0; dcyc = 0; cyc = 0;
    finished = 0; prev_halt = 0;
    halt_at = h;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!finished && cyc < 3000) begin
      start = 1'b0;
      halt_noise = 1'($urandom_range(0, 1));
      if (done) finished = 1;
      else begin
        chk("busy", 32'(busy), 32'd1);
        if (mem_we) begin
          if (nw < PW) begin
            chk("load_addr", 32'(mem_addr), 32'(nw));
            chk("load_data", mem_wdata, rom[nw]);
          end else begin
            chk("clear_addr", 32'(mem_addr), 32'(DB + nw - PW));
            chk("clear_data", mem_wdata, 32'd0);
          end
          chk("we_ctl", 32'({mem_sel, core_reset, core_stall}), 32'b110);
          nw++;
        end
        if (prev_halt) chk("stall_after_halt", 32'(core_stall), 32'd1);
        prev_halt = in_run && halt;
        if (in_run) begin
          nrun++;
          chk("run_mem", 32'({mem_sel, mem_we}), 32'd0);
          if (mid_start && nrun == 5) start = 1'b1;
        end
        if (core_stall && !mem_sel) begin
          if (nchk < NC) chk("reg_rd_addr", 32'(reg_rd_addr), 32'(chk_reg[nchk*5 +: 5]));
          nchk++;
        end
`ifdef RUN_CTRL_DUMP_EN
        if (core_stall && mem_sel) begin
          chk("dump_valid", 32'(dump_valid), 32'd1);
          chk("dump_addr", 32'(mem_addr), 32'(DB + ndump));
          chk("dump_data", dump_data, mem[DB + ndump]);
          dump_ready = (dcyc < 5) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
          if (dump_ready) ndump++;
          dcyc++;
        end else dump_ready = 1'($urandom_range(0, 1));
`endif
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_reached", 32'(done), 32'd1);
    chk("pass", 32'(pass), 32'(exp_err == 0));
    chk("err_count", 32'(err_count), 32'(exp_err));
    chk("fail_idx", 32'(fail_idx), 32'(exp_fail));
    chk("cycle_count", 32'(cycle_count), 32'(exp_cyc));
    chk("done_ctl", 32'({busy, core_reset, core_stall, mem_sel, mem_we}), 32'b00100);
    chk("n_writes", 32'(nw), 32'(PW + CW));
    chk("n_run", 32'(nrun), 32'(exp_cyc));
    chk("n_checks", 32'(nchk), 32'(NC));
`ifdef RUN_CTRL_DUMP_EN
    chk("n_dump", 32'(ndump), 32'(DW));
`endif
    bad = 0;
    for (int k = 0; k < PW; k++) if (mem[k] != rom[k]) bad++;
    for (int j = DW; j < CW; j++) if (mem[DB + j] != 32'd0) bad++;
    chk("mem_image", 32'(bad), 32'd0);
    @(negedge clk);
    chk("done_held", 32'({done, pass}), 32'({1'b1, exp_err == 0}));
    halt_at = 0;
  endtask

  initial begin
    int n;
    for (int k = 0; k < (1 << AW); k++) rom[k] = 32'd0;
    setup('0);
    repeat (3) @(negedge clk);
    chk("rst_status", 32'({busy, done, pass}), 32'd0);
    chk("rst_counts", {err_count, fail_idx, cycle_count}, 32'h00FF_0000);
    chk("rst_core", 32'({core_reset, core_stall}), 32'b10);
    chk("rst_mem", 32'({mem_sel, mem_we, mem_addr}), 32'd0);
    chk("rst_addr", 32'({rom_addr, reg_rd_addr}), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
`ifdef RUN_CTRL_DUMP_EN
    chk("rst_dump_valid", 32'(dump_valid), 32'd0);
`endif
    reset = 1'b1;
    @(negedge clk);
    chk("idle_start_low", 32'(busy), 32'd0);

    // Reference program: x5=8, x6=0x14, x7=0x14, no halt.
    setup('0);
    regs[5] = 32'h8; regs[6] = 32'h14; regs[7] = 32'h14;
    chk_reg = {5'd7, 5'd6, 5'd5};
    chk_val = {32'h14, 32'h14, 32'h8};
    run_check(0, 0);
    chk("pin_cycles_50", 32'(cycle_count), 32'd50);
    chk("pin_pass_1", 32'({pass, err_count}), 32'h100);
    chk("pin_fail_none", 32'(fail_idx), 32'hFF);

    chk_val = {32'h14, 32'h15, 32'h8};
    run_check(0, 0);
    chk("pin_mis_pass", 32'(pass), 32'd0);
    chk("pin_mis_err", 32'(err_count), 32'd1);
    chk("pin_mis_idx", 32'(fail_idx), 32'd1);

    setup('0);
    run_check(10, 0);
    chk("pin_halt10", 32'(cycle_count), 32'd10);

    // Reset in the middle of LOAD, then a fresh start must reload from word 0.
    setup(3'b101);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!(mem_we && mem_addr == 14'd20) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_load20", 32'(mem_addr), 32'd20);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrst_ctl", 32'({busy, core_reset, mem_sel, mem_we}), 32'b0100);
    chk("midrst_addr", 32'({rom_addr, mem_addr}), 32'd0);
    chk("midrst_fail", 32'(fail_idx), 32'hFF);
    run_check(0, 0);

    setup(3'b010);
    run_check(30, 1);
    setup('0);
    run_check(50, 1);
    setup(3'b111);
    run_check(1, 0);

    for (int t = 0; t < 8; t++) begin
      setup(NC'($urandom));
      run_check($urandom_range(0, 60), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end

endmodule
